simple_axi_burst_master: RTL and testbench

- Parametrised successor to the single-beat host-to-AXI4 master. Converts one host command into one AXI4 INCR burst of 1..C_MAX_BURST beats on a C_AXI_DATA_WIDTH bus.
- Supports narrow transfers with lane steering and generates strobes per beat.
- Streams write and read data one beat at a time over the host bus.
- Sits between a CPU/DMA-style host and the AXI interconnect.

---
 rtl/simple_axi_burst_master.sv | 279 +++++++++++++++++++++++++++
 tb/tb_simple_axi_burst_master.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_axi_burst_master.sv
// simple_axi_burst_master
//   Converts one host command into one AXI4 INCR burst of 1..C_MAX_BURST beats.
//   Handles narrow transfers: each beat is steered to its byte lane (address
//   modulo bus width), and write strobes are generated per beat. Write and read
//   data move across the host bus one beat at a time, right-justified.
//
// Ports
//   i_clk, i_rstn              clock, asynchronous active-low reset
//   i_rw/i_addr/i_size/i_len   command: 01 read, 10 write, 11 illegal; start
//                              address, log2 bytes per beat, beats minus one
//   i_wdata/i_wvalid/o_wready  host write beat stream (right-justified)
//   o_rdata/o_rvalid           host read beat stream (one-cycle pulse per beat)
//   o_wait                     burst in progress
//   i_clear                    clears sticky flags (in DONE or IDLE)
//   o_done/o_error/o_invalid   sticky status
//   o_debug_state              FSM state
//   m_axi_*                    AXI4 master channels AW, W, B, AR, R
module simple_axi_burst_master #(
  parameter int C_AXI_DATA_WIDTH = 64,
  parameter int C_ADDR_WIDTH     = 32,
  parameter int C_MAX_BURST      = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic [1:0]                    i_rw,
  input  logic [C_ADDR_WIDTH-1:0]       i_addr,
  input  logic [2:0]                    i_size,
  input  logic [7:0]                    i_len,
  input  logic [C_AXI_DATA_WIDTH-1:0]   i_wdata,
  input  logic                          i_wvalid,
  output logic                          o_wready,
  output logic [C_AXI_DATA_WIDTH-1:0]   o_rdata,
  output logic                          o_rvalid,
  output logic                          o_wait,
  input  logic                          i_clear,
  output logic                          o_done,
  output logic                          o_error,
  output logic                          o_invalid,
  output logic [3:0]                    o_debug_state,
  // write address
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_ADDR_WIDTH-1:0]       m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic [3:0]                    m_axi_awcache,
  output logic [2:0]                    m_axi_awprot,
  // write data
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                          m_axi_wlast,
  // write response
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  input  logic [1:0]                    m_axi_bresp,
  // read address
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0]       m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic [3:0]                    m_axi_arcache,
  output logic [2:0]                    m_axi_arprot,
  // read data
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast
);

  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int AW = C_ADDR_WIDTH;
  localparam int SB = DW / 8;          // bytes per bus word
  localparam int LW = $clog2(SB);      // byte-lane index width

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_AR   = 4'd1,
    S_R    = 4'd2,
    S_AW   = 4'd3,
    S_W    = 4'd4,
    S_B    = 4'd5,
    S_DONE = 4'd6
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q;             // address of the current beat
  logic [2:0]      size_q;
  logic [7:0]      len_q;
  logic [7:0]      beat_q;
  logic            done_q, error_q, invalid_q;
  logic [DW-1:0]   rdata_q;
  logic            rvalid_q;

  // ---------------------------------------------------------------------------
  // Command qualification
  // ---------------------------------------------------------------------------
  logic            flags_set, accept, cmd_invalid;
  logic            size_bad, len_bad, align_bad, cross_bad;
  logic [19:0]     end_off;

  assign flags_set = done_q | error_q | invalid_q;
  // Clear beats a simultaneous command; any sticky flag blocks new commands.
  assign accept    = (state_q == S_IDLE) && (i_rw != 2'b00) && !flags_set && !i_clear;

  always_comb begin
    size_bad  = (i_size > 3'(LW));
    len_bad   = ({24'd0, i_len} >= 32'(C_MAX_BURST));
    align_bad = (i_addr[11:0] & ((12'd1 << i_size) - 12'd1)) != 12'd0;
    // One past the last byte, relative to the 4 KB page; landing exactly on
    // 4096 is fine, beyond it the burst would straddle two pages. 20 bits
    // hold the worst case (256 beats << 7).
    end_off   = {8'd0, i_addr[11:0]} + (({12'd0, i_len} + 20'd1) << i_size);
    cross_bad = (end_off > 20'd4096);
    cmd_invalid = (i_rw == 2'b11) | size_bad | len_bad | align_bad | cross_bad;
  end

  // ---------------------------------------------------------------------------
  // Lane steering
  // ---------------------------------------------------------------------------
  logic [LW-1:0]   lane;
  logic [SB-1:0]   strb_base;          // (1<<size) ones at lane 0
  logic [DW-1:0]   byte_mask;          // strb_base expanded to bits
  logic [DW-1:0]   rdata_ext;
  logic [AW-1:0]   step;

  assign lane = addr_q[LW-1:0];
  assign step = {{(AW-1){1'b0}}, 1'b1} << size_q;

  always_comb begin
    strb_base = '0;
    byte_mask = '0;
    for (int i = 0; i < SB; i++) begin
      strb_base[i]        = (i < (1 << size_q));
      byte_mask[i*8 +: 8] = {8{strb_base[i]}};
    end
  end

  // Host data is right-justified; only the active bytes are placed on the bus.
  assign m_axi_wdata = (i_wdata & byte_mask) << {lane, 3'b000};
  assign m_axi_wstrb = strb_base << lane;
  assign m_axi_wlast = (state_q == S_W) && (beat_q == len_q);
  assign rdata_ext   = (m_axi_rdata >> {lane, 3'b000}) & byte_mask;

  // ---------------------------------------------------------------------------
  // Channel constants and latched command fields
  // ---------------------------------------------------------------------------
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = size_q;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = size_q;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;

  assign o_rdata       = rdata_q;
  assign o_rvalid      = rvalid_q;
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign o_invalid     = invalid_q;
  assign o_debug_state = state_q;
  assign o_wait        = (state_q == S_AR) || (state_q == S_R) || (state_q == S_AW) ||
                         (state_q == S_W)  || (state_q == S_B);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    m_axi_awvalid = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    o_wready      = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_rready  = 1'b0;
    unique case (state_q)
      S_IDLE: if (accept) state_d = cmd_invalid     ? S_DONE :
                                    (i_rw == 2'b01) ? S_AR   : S_AW;
      S_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = S_R;
      end
      S_R: begin
        m_axi_rready = 1'b1;
        // Only rlast ends the burst, even if it arrives early or late.
        if (m_axi_rvalid && m_axi_rlast) state_d = S_DONE;
      end
      S_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = S_W;
      end
      S_W: begin
        m_axi_wvalid = i_wvalid;
        o_wready     = m_axi_wready;
        if (i_wvalid && m_axi_wready && (beat_q == len_q)) state_d = S_B;
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_d = S_DONE;
      end
      S_DONE: if (i_clear) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath, beat counter and sticky flags
  // ---------------------------------------------------------------------------
  logic r_hs, w_hs, b_hs;
  assign r_hs = (state_q == S_R) && m_axi_rvalid;
  assign w_hs = (state_q == S_W) && i_wvalid && m_axi_wready;
  assign b_hs = (state_q == S_B) && m_axi_bvalid;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      addr_q    <= '0;
      size_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      invalid_q <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (accept) begin
        addr_q <= i_addr;
        size_q <= i_size;
        len_q  <= i_len;
        beat_q <= 8'd0;
        if (cmd_invalid) begin
          invalid_q <= 1'b1;
          done_q    <= 1'b1;
        end
      end
      if (r_hs) begin
        rdata_q  <= rdata_ext;
        rvalid_q <= 1'b1;
        addr_q   <= addr_q + step;
        beat_q   <= beat_q + 8'd1;
        // Error on bad response, on rlast before the final counted beat, or
        // on the final counted beat arriving without rlast.
        if ((m_axi_rresp != 2'b00) || (m_axi_rlast != (beat_q == len_q)))
          error_q <= 1'b1;
        if (m_axi_rlast) done_q <= 1'b1;
      end
      if (w_hs) begin
        addr_q <= addr_q + step;
        beat_q <= beat_q + 8'd1;
      end
      if (b_hs) begin
        if (m_axi_bresp != 2'b00) error_q <= 1'b1;
        done_q <= 1'b1;
      end
      if (i_clear && ((state_q == S_DONE) || (state_q == S_IDLE))) begin
        done_q    <= 1'b0;
        error_q   <= 1'b0;
        invalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_simple_axi_burst_master.sv
// Testbench for simple_axi_burst_master (DW=64, AW=32, MAX_BURST=16).
// Scenario tasks drive a host and an AXI slave, and compare against a
// byte-level reference model of lane steering and command legality.
module tb_simple_axi_burst_master;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic i_rstn = 1'b0;
  logic [1:0] i_rw = '0;
  logic [AW-1:0] i_addr = '0;
  logic [2:0] i_size = '0;
  logic [7:0] i_len = '0;
  logic [DW-1:0] i_wdata = '0;
  logic i_wvalid = 1'b0, o_wready;
  logic [DW-1:0] o_rdata;
  logic o_rvalid, o_wait, i_clear = 1'b0, o_done, o_error, o_invalid;
  logic [3:0] o_debug_state;
  logic m_axi_awvalid, m_axi_awready = 1'b0;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0] m_axi_awlen;
  logic [2:0] m_axi_awsize, m_axi_awprot;
  logic [1:0] m_axi_awburst;
  logic [3:0] m_axi_awcache;
  logic m_axi_wvalid, m_axi_wready = 1'b0, m_axi_wlast;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic m_axi_bvalid = 1'b0, m_axi_bready;
  logic [1:0] m_axi_bresp = '0;
  logic m_axi_arvalid, m_axi_arready = 1'b0;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize, m_axi_arprot;
  logic [1:0] m_axi_arburst;
  logic [3:0] m_axi_arcache;
  logic m_axi_rvalid = 1'b0, m_axi_rready, m_axi_rlast = 1'b0;
  logic [DW-1:0] m_axi_rdata = '0;
  logic [1:0] m_axi_rresp = '0;

  always #5 clk = ~clk;

  simple_axi_burst_master #(.C_AXI_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW), .C_MAX_BURST(MB)) dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_rw(i_rw), .i_addr(i_addr), .i_size(i_size), .i_len(i_len),
    .i_wdata(i_wdata), .i_wvalid(i_wvalid), .o_wready(o_wready), .o_rdata(o_rdata),
    .o_rvalid(o_rvalid), .o_wait(o_wait), .i_clear(i_clear), .o_done(o_done),
    .o_error(o_error), .o_invalid(o_invalid), .o_debug_state(o_debug_state),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus data and observations
  logic [DW-1:0] hw_data [256];
  logic [DW-1:0] rd_data [256];
  logic [1:0]    rr      [256];
  logic [DW-1:0] obs_wdata [$];
  logic [7:0]    obs_wstrb [$];
  logic          obs_wlast [$];
  logic [DW-1:0] obs_rdata [$];
  logic [AW-1:0] cap_addr;
  logic [7:0]    cap_len;
  logic [2:0]    cap_size, cap_prot;
  logic [1:0]    cap_burst;
  logic [3:0]    cap_cache;
  int            n_beats;
  bit            timeout, wait_seen, w_before_aw;

  // ---------------- reference model ----------------
  function automatic logic [63:0] exp_rd(input logic [63:0] d, input int lane, input int bytes);
    logic [63:0] r;
    r = d >> (8 * lane);
    for (int b = 0; b < 8; b++) if (b >= bytes) r[b*8 +: 8] = 8'h00;
    return r;
  endfunction

  function automatic logic [7:0] exp_strb(input int lane, input int bytes);
    logic [7:0] s;
    s = '0;
    for (int b = 0; b < 8; b++) if (b >= lane && b < lane + bytes) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] exp_wd(input logic [63:0] d, input int lane, input int bytes);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < bytes; b++) r[(lane+b)*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] strb_bits(input logic [7:0] s);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{s[b]}};
    return m;
  endfunction

  function automatic bit model_invalid(input logic [1:0] rw, input int off, input int sz, input int ln);
    int bytes;
    bytes = 1 << sz;
    return (rw == 2'b11) || (bytes > DW/8) || (ln >= MB) || ((off % bytes) != 0) ||
           (off + (ln + 1) * bytes > 4096);
  endfunction

  // ---------------- host / slave drivers (no checks) ----------------
  task automatic issue(input logic [1:0] rw, input logic [AW-1:0] a, input logic [2:0] sz, input logic [7:0] ln);
    @(posedge clk); #1;
    i_rw = rw; i_addr = a; i_size = sz; i_len = ln;
    @(posedge clk); #1;
    i_rw = 2'b00;
  endtask

  task automatic do_clear;
    @(posedge clk); #1 i_clear = 1'b1;
    @(posedge clk); #1 i_clear = 1'b0;
  endtask

  task automatic run_write(input int ln, input int aw_dly, input bit gaps, input logic [1:0] bresp_v);
    int cyc, awc, beat;
    bit aw_ok, fin;
    cyc = 0; awc = 0; beat = 0; aw_ok = 0; fin = 0;
    obs_wdata.delete(); obs_wstrb.delete(); obs_wlast.delete();
    timeout = 0; wait_seen = 0; w_before_aw = 0;
    while (!fin && cyc < 400) begin
      @(negedge clk); cyc++;
      if (o_wait) wait_seen = 1;
      m_axi_awready = m_axi_awvalid && (awc >= aw_dly);
      if (m_axi_awvalid) awc++;
      i_wvalid     = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      i_wdata      = hw_data[beat % 256];
      m_axi_wready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      m_axi_bvalid = (beat > ln);
      m_axi_bresp  = bresp_v;
      #1;
      if (m_axi_wvalid && !aw_ok) w_before_aw = 1;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_ok = 1;
        cap_addr = m_axi_awaddr; cap_len = m_axi_awlen; cap_size = m_axi_awsize;
        cap_burst = m_axi_awburst; cap_cache = m_axi_awcache; cap_prot = m_axi_awprot;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        obs_wdata.push_back(m_axi_wdata); obs_wstrb.push_back(m_axi_wstrb);
        obs_wlast.push_back(m_axi_wlast); beat++;
      end
      if (m_axi_bvalid && m_axi_bready) fin = 1;
    end
    @(negedge clk);
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0; i_wvalid = 0;
    n_beats = beat;
    timeout = !fin;
  endtask

  task automatic run_read(input int ar_dly, input bit gaps, input int last_idx);
    int cyc, arc, k, post;
    bit ar_ok, fin;
    cyc = 0; arc = 0; k = 0; post = 0; ar_ok = 0; fin = 0;
    obs_rdata.delete();
    timeout = 0; wait_seen = 0;
    while (post < 3 && cyc < 400) begin
      @(negedge clk); cyc++;
      if (o_rvalid) obs_rdata.push_back(o_rdata);
      if (o_wait) wait_seen = 1;
      if (fin) begin
        post++;
        m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0; m_axi_arready = 0;
      end else begin
        m_axi_arready = m_axi_arvalid && (arc >= ar_dly);
        if (m_axi_arvalid) arc++;
        m_axi_rvalid = ar_ok && (gaps ? ($urandom_range(0, 2) != 0) : 1'b1);
        m_axi_rdata  = rd_data[k % 256];
        m_axi_rresp  = rr[k % 256];
        m_axi_rlast  = (k == last_idx);
        #1;
        if (m_axi_arvalid && m_axi_arready) begin
          ar_ok = 1;
          cap_addr = m_axi_araddr; cap_len = m_axi_arlen; cap_size = m_axi_arsize;
          cap_burst = m_axi_arburst; cap_cache = m_axi_arcache; cap_prot = m_axi_arprot;
        end
        if (m_axi_rvalid && m_axi_rready) begin
          if (k == last_idx) fin = 1;
          k++;
        end
      end
    end
    n_beats = k;
    timeout = !fin;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    i_rstn = 0;
    #12;
    n_tests++; if (o_wait !== 1'b0 || o_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_wait_rvalid got=%b%b exp=00", o_wait, o_rvalid); end
    n_tests++; if ({o_done, o_error, o_invalid} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {o_done, o_error, o_invalid}); end
    n_tests++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0) begin n_fail++; $display("FAIL reset_axi_handshakes got=%b exp=00000", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}); end
    n_tests++; if (o_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", o_rdata); end
    n_tests++; if (o_debug_state !== 4'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", o_debug_state); end
    @(posedge clk); #1 i_rstn = 1;
  endtask

  task automatic test_write_basic;
    for (int k = 0; k < 4; k++) hw_data[k] = {$urandom, $urandom};
    issue(2'b10, 32'h100, 3'd3, 8'd3);
    run_write(3, 2, 0, 2'b00);
    n_tests++; if (timeout) begin n_fail++; $display("FAIL wr_basic_timeout got=timeout exp=done"); end
    n_tests++; if (cap_addr !== 32'h100 || cap_len !== 8'd3 || cap_size !== 3'd3) begin n_fail++; $display("FAIL wr_basic_aw got=%h/%0d/%0d exp=100/3/3", cap_addr, cap_len, cap_size); end
    n_tests++; if (cap_burst !== 2'b01 || cap_cache !== 4'b0011 || cap_prot !== 3'b000) begin n_fail++; $display("FAIL wr_basic_awconst got=%b/%b/%b exp=01/0011/000", cap_burst, cap_cache, cap_prot); end
    n_tests++; if (n_beats !== 4) begin n_fail++; $display("FAIL wr_basic_beats got=%0d exp=4", n_beats); end
    n_tests++; if (w_before_aw || !wait_seen) begin n_fail++; $display("FAIL wr_basic_order got=wbefore%0d wait%0d exp=wbefore0 wait1", w_before_aw, wait_seen); end
    for (int k = 0; k < obs_wdata.size() && k < 4; k++) begin
      n_tests++; if (obs_wstrb[k] !== 8'hFF || obs_wdata[k] !== hw_data[k]) begin n_fail++; $display("FAIL wr_basic_beat%0d got=%h/%h exp=%h/ff", k, obs_wdata[k], obs_wstrb[k], hw_data[k]); end
      n_tests++; if (obs_wlast[k] !== (k == 3)) begin n_fail++; $display("FAIL wr_basic_wlast%0d got=%b exp=%b", k, obs_wlast[k], k == 3); end
    end
    n_tests++; if ({o_done, o_error, o_invalid, o_wait} !== 4'b1000) begin n_fail++; $display("FAIL wr_basic_flags got=%b exp=1000", {o_done, o_error, o_invalid, o_wait}); end
    n_tests++; if (o_debug_state !== 4'd6) begin n_fail++; $display("FAIL wr_basic_state got=%0d exp=6", o_debug_state); end
    do_clear;
    n_tests++; if (o_done !== 1'b0 || o_debug_state !== 4'd0) begin n_fail++; $display("FAIL clear got=done%b st%0d exp=done0 st0", o_done, o_debug_state); end
  endtask

  task automatic test_narrow_read;
    for (int k = 0; k < 3; k++) begin rd_data[k] = {$urandom, $urandom}; rr[k] = 2'b00; end
    issue(2'b01, 32'h102, 3'd1, 8'd2);
    run_read(1, 0, 2);
    n_tests++; if (timeout || cap_addr !== 32'h102 || cap_size !== 3'd1 || cap_len !== 8'd2) begin n_fail++; $display("FAIL rd_narrow_ar got=%h/%0d/%0d to%0d exp=102/1/2", cap_addr, cap_size, cap_len, timeout); end
    n_tests++; if (obs_rdata.size() !== 3) begin n_fail++; $display("FAIL rd_narrow_pulses got=%0d exp=3", obs_rdata.size()); end
    for (int k = 0; k < obs_rdata.size() && k < 3; k++) begin
      n_tests++; if (obs_rdata[k] !== exp_rd(rd_data[k], 2 + 2*k, 2)) begin n_fail++; $display("FAIL rd_narrow_data%0d got=%h exp=%h", k, obs_rdata[k], exp_rd(rd_data[k], 2 + 2*k, 2)); end
    end
    n_tests++; if ({o_done, o_error} !== 2'b10) begin n_fail++; $display("FAIL rd_narrow_flags got=%b exp=10", {o_done, o_error}); end
    do_clear;
  endtask

  task automatic test_read_slverr;
    bit arv;
    for (int k = 0; k < 4; k++) begin rd_data[k] = {$urandom, $urandom}; rr[k] = (k == 1) ? 2'b10 : 2'b00; end
    issue(2'b01, 32'h200, 3'd3, 8'd3);
    run_read(0, 1, 3);
    n_tests++; if (timeout || n_beats !== 4 || obs_rdata.size() !== 4) begin n_fail++; $display("FAIL rd_slverr_beats got=%0d/%0d exp=4/4", n_beats, obs_rdata.size()); end
    n_tests++; if ({o_done, o_error} !== 2'b11) begin n_fail++; $display("FAIL rd_slverr_flags got=%b exp=11", {o_done, o_error}); end
    issue(2'b01, 32'h0, 3'd3, 8'd0);
    arv = 0;
    repeat (3) begin @(negedge clk); if (m_axi_arvalid) arv = 1; end
    n_tests++; if (arv || o_debug_state !== 4'd6) begin n_fail++; $display("FAIL rd_slverr_blocked got=arv%0d st%0d exp=arv0 st6", arv, o_debug_state); end
    do_clear;
    n_tests++; if ({o_done, o_error, o_invalid} !== 3'b000) begin n_fail++; $display("FAIL rd_slverr_clear got=%b exp=000", {o_done, o_error, o_invalid}); end
  endtask

  task automatic test_invalid;
    logic [1:0] rws [5]  = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b01};
    logic [31:0] as [5]  = '{32'hFF8, 32'h101, 32'h100, 32'h0, 32'h0};
    logic [2:0] szs [5]  = '{3'd3, 3'd2, 3'd0, 3'd3, 3'd4};
    logic [7:0] lns [5]  = '{8'd1, 8'd0, 8'd0, 8'd16, 8'd0};
    bit any_v;
    for (int c = 0; c < 5; c++) begin
      any_v = 0;
      issue(rws[c], as[c], szs[c], lns[c]);
      repeat (4) begin @(negedge clk); if (m_axi_arvalid || m_axi_awvalid) any_v = 1; end
      n_tests++; if (any_v) begin n_fail++; $display("FAIL invalid%0d_axi got=valid exp=none", c); end
      n_tests++; if ({o_invalid, o_done, o_wait} !== 3'b110 || o_debug_state !== 4'd6) begin n_fail++; $display("FAIL invalid%0d_flags got=%b st%0d exp=110 st6", c, {o_invalid, o_done, o_wait}, o_debug_state); end
      do_clear;
    end
  endtask

  task automatic test_boundary;
    // 16 beats of 8 bytes ending exactly at the 4 KB line: legal.
    for (int k = 0; k < 16; k++) hw_data[k] = {$urandom, $urandom};
    issue(2'b10, 32'h0000_1F80, 3'd3, 8'd15);
    run_write(15, 0, 1, 2'b00);
    n_tests++; if (timeout || n_beats !== 16 || o_invalid !== 1'b0) begin n_fail++; $display("FAIL boundary got=beats%0d inv%b exp=beats16 inv0", n_beats, o_invalid); end
    n_tests++; if (obs_wlast.size() == 16 && (obs_wlast[15] !== 1'b1 || obs_wlast[14] !== 1'b0)) begin n_fail++; $display("FAIL boundary_wlast got=%b%b exp=01", obs_wlast[14], obs_wlast[15]); end
    do_clear;
  endtask

  task automatic test_reset_mid_write;
    int hs, cyc;
    bit hit;
    hs = 0; cyc = 0; hit = 0;
    for (int k = 0; k < 4; k++) hw_data[k] = {$urandom, $urandom};
    issue(2'b10, 32'h80, 3'd3, 8'd3);
    while (!hit && cyc < 50) begin
      @(negedge clk); cyc++;
      m_axi_awready = 1; m_axi_wready = 1; i_wvalid = 1; i_wdata = hw_data[hs];
      #1;
      if (m_axi_wvalid && m_axi_wready) begin
        if (hs == 1) begin
          hit = 1;
          i_rstn = 0;
          #1;
          n_tests++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, o_wait} !== 5'b0) begin n_fail++; $display("FAIL rst_mid_drop got=%b exp=00000", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, o_wait}); end
        end else hs++;
      end
    end
    n_tests++; if (!hit) begin n_fail++; $display("FAIL rst_mid_reach got=no_beat2 exp=beat2"); end
    m_axi_awready = 0; m_axi_wready = 0; i_wvalid = 0;
    @(posedge clk); #1 i_rstn = 1;
    @(negedge clk);
    n_tests++; if (o_debug_state !== 4'd0 || {o_done, o_error, o_invalid} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_idle got=st%0d fl%b exp=st0 fl000", o_debug_state, {o_done, o_error, o_invalid}); end
    for (int k = 0; k < 2; k++) hw_data[k] = {$urandom, $urandom};
    issue(2'b10, 32'h40, 3'd3, 8'd1);
    run_write(1, 0, 0, 2'b00);
    n_tests++; if (timeout || n_beats !== 2 || {o_done, o_error} !== 2'b10) begin n_fail++; $display("FAIL rst_mid_fresh got=beats%0d fl%b exp=beats2 fl10", n_beats, {o_done, o_error}); end
    n_tests++; if (obs_wdata.size() == 2 && obs_wdata[1] !== hw_data[1]) begin n_fail++; $display("FAIL rst_mid_data got=%h exp=%h", obs_wdata[1], hw_data[1]); end
    do_clear;
  endtask

  task automatic test_early_rlast;
    for (int k = 0; k < 4; k++) begin rd_data[k] = {$urandom, $urandom}; rr[k] = 2'b00; end
    issue(2'b01, 32'h300, 3'd3, 8'd3);
    run_read(0, 0, 1);
    n_tests++; if (timeout || n_beats !== 2) begin n_fail++; $display("FAIL early_rlast_beats got=%0d exp=2", n_beats); end
    n_tests++; if ({o_done, o_error} !== 2'b11 || o_debug_state !== 4'd6) begin n_fail++; $display("FAIL early_rlast_flags got=%b st%0d exp=11 st6", {o_done, o_error}, o_debug_state); end
    n_tests++; if (m_axi_rready !== 1'b0) begin n_fail++; $display("FAIL early_rlast_rready got=%b exp=0", m_axi_rready); end
    do_clear;
  endtask

  task automatic test_random;
    logic [1:0] rw;
    int sz, ln, off, bytes;
    logic [AW-1:0] a;
    logic [1:0] bresp_v;
    bit inv, exp_err, any_v;
    logic [7:0] es;
    for (int it = 0; it < 40; it++) begin
      rw  = $urandom_range(0, 1) ? 2'b01 : 2'b10;
      if ($urandom_range(0, 19) == 0) rw = 2'b11;
      sz  = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) sz = 4;
      ln  = $urandom_range(0, 15);
      if ($urandom_range(0, 9) == 0) ln = $urandom_range(16, 20);
      bytes = 1 << sz;
      off = $urandom_range(0, 4095);
      if ($urandom_range(0, 4) != 0) off = off - (off % bytes);
      a   = ($urandom() & 32'hFFFF_F000) | 32'(off);
      inv = model_invalid(rw, off, sz, ln);
      issue(rw, a, 3'(sz), 8'(ln));
      if (inv) begin
        any_v = 0;
        repeat (3) begin @(negedge clk); if (m_axi_arvalid || m_axi_awvalid) any_v = 1; end
        n_tests++; if (any_v || {o_invalid, o_done} !== 2'b11) begin n_fail++; $display("FAIL rnd%0d_invalid got=v%0d fl%b exp=v0 fl11", it, any_v, {o_invalid, o_done}); end
      end else if (rw == 2'b01) begin
        exp_err = 0;
        for (int k = 0; k <= ln; k++) begin
          rd_data[k] = {$urandom, $urandom};
          rr[k] = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00;
          if (rr[k] != 2'b00) exp_err = 1;
        end
        run_read($urandom_range(0, 2), 1, ln);
        n_tests++; if (timeout || obs_rdata.size() !== ln + 1 || cap_addr !== a) begin n_fail++; $display("FAIL rnd%0d_rd_shape got=%0d/%h exp=%0d/%h", it, obs_rdata.size(), cap_addr, ln + 1, a); end
        for (int k = 0; k < obs_rdata.size() && k <= ln; k++) begin
          n_tests++; if (obs_rdata[k] !== exp_rd(rd_data[k], (off + k*bytes) % 8, bytes)) begin n_fail++; $display("FAIL rnd%0d_rd%0d got=%h exp=%h", it, k, obs_rdata[k], exp_rd(rd_data[k], (off + k*bytes) % 8, bytes)); end
        end
        n_tests++; if ({o_done, o_error, o_invalid} !== {1'b1, exp_err, 1'b0}) begin n_fail++; $display("FAIL rnd%0d_rd_flags got=%b exp=%b", it, {o_done, o_error, o_invalid}, {1'b1, exp_err, 1'b0}); end
      end else begin
        for (int k = 0; k <= ln; k++) hw_data[k] = {$urandom, $urandom};
        bresp_v = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00;
        run_write(ln, $urandom_range(0, 2), 1, bresp_v);
        n_tests++; if (timeout || n_beats !== ln + 1 || w_before_aw || cap_addr !== a) begin n_fail++; $display("FAIL rnd%0d_wr_shape got=%0d/%h wb%0d exp=%0d/%h", it, n_beats, cap_addr, w_before_aw, ln + 1, a); end
        for (int k = 0; k < obs_wdata.size() && k <= ln; k++) begin
          es = exp_strb((off + k*bytes) % 8, bytes);
          n_tests++; if (obs_wstrb[k] !== es || (obs_wdata[k] & strb_bits(es)) !== exp_wd(hw_data[k], (off + k*bytes) % 8, bytes) || obs_wlast[k] !== (k == ln)) begin
            n_fail++; $display("FAIL rnd%0d_wr%0d got=%h/%h/%b exp=%h/%h/%b", it, k, obs_wdata[k], obs_wstrb[k], obs_wlast[k], exp_wd(hw_data[k], (off + k*bytes) % 8, bytes), es, k == ln);
          end
        end
        n_tests++; if ({o_done, o_error, o_invalid} !== {1'b1, bresp_v != 2'b00, 1'b0}) begin n_fail++; $display("FAIL rnd%0d_wr_flags got=%b exp=%b", it, {o_done, o_error, o_invalid}, {1'b1, bresp_v != 2'b00, 1'b0}); end
      end
      do_clear;
    end
  endtask

  initial begin
    test_reset;
    test_write_basic;
    test_narrow_read;
    test_read_slverr;
    test_invalid;
    test_boundary;
    test_reset_mid_write;
    test_early_rlast;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
